regfile_sweep: RTL and testbench

//   Parametrised 2-read/1-write register file for the datapath, successor to the fixed 32x32 file.

---
 rtl/regfile_sweep.sv | 144 ++++++++++++++
 tb/tb_regfile_sweep.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sweep.sv
// Parametrised 2R/1W register file with byte-masked writes, optional zero register and a sequenced sweep clear.
// Optional write-first read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sweep #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Write_reg,
    input  logic [ADDR_W-1:0]     W_Addr,
    input  logic [DATA_W-1:0]     W_Data,
    input  logic [DATA_W/8-1:0]   W_Mask,
    input  logic [ADDR_W-1:0]     R_Addr_A,
    input  logic [ADDR_W-1:0]     R_Addr_B,
    output logic [DATA_W-1:0]     R_Data_A,
    output logic [DATA_W-1:0]     R_Data_B,
    input  logic                  Clear,
    output logic                  Busy,
    output logic                  Clear_done,
    output logic                  Wr_drop
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                drop_q, drop_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_acc_s;
    logic [DATA_W-1:0]   wr_merged_s;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                      input logic [DATA_W-1:0] new_v,
                                                      input logic [NB-1:0]     mask);
        logic [DATA_W-1:0] res;
        for (int k = 0; k < NB; k++) begin
            res[8*k +: 8] = mask[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return res;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
    endfunction

    // A write takes effect only outside the sweep and never on the hard-wired zero entry.
    always_comb begin
        wr_acc_s    = Write_reg && (state_q == S_IDLE) && !is_zero_reg(W_Addr);
        wr_merged_s = merge_bytes(mem_q[W_Addr], W_Data, W_Mask);
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] res;
        if (is_zero_reg(addr)) begin
            res = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (wr_acc_s && (addr == W_Addr)) begin
            res = wr_merged_s;
`endif
        end else begin
            res = mem_q[addr];
        end
        return res;
    endfunction

    // Asynchronous read ports.
    always_comb begin
        R_Data_A = read_port(R_Addr_A);
        R_Data_B = read_port(R_Addr_B);
    end

    // Sweep sequencer next-state and pulse generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                drop_d = Write_reg;
                if (cnt_q == ADDR_W'(DEPTH-1)) begin
                    state_d = S_IDLE;
                    cnt_d   = {ADDR_W{1'b0}};
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Sequencer state and registered status pulses.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    // Storage array: reset clears everything, the sweep clears one entry per cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (state_q == S_CLEAR) begin
            mem_q[cnt_q] <= {DATA_W{1'b0}};
        end else if (wr_acc_s) begin
            mem_q[W_Addr] <= wr_merged_s;
        end
    end

    assign Busy       = (state_q == S_CLEAR);
    assign Clear_done = done_q;
    assign Wr_drop    = drop_q;

endmodule

// File: tb/tb_regfile_sweep.sv
// Randomised and directed bench for regfile_sweep; a ZERO_REG=1 and a ZERO_REG=0 instance share all inputs.
`timescale 1ns/1ns
module tb_regfile_sweep;
    logic        clk = 1'b0;
    logic        rst_n, we, clr;
    logic [4:0]  wa, ra, rb;
    logic [31:0] wd;
    logic [3:0]  wm;

    logic [31:0] rda1, rdb1, rda0, rdb0;
    logic        busy1, done1, drop1, busy0, done0, drop0;

    logic [31:0] ref_mem [2][32];
    int          ref_sweep;
    bit          ref_done, ref_drop;
    int          nvec = 0;
    int          nerr = 0;
    int          busy_cycles, done_cycles;
    logic [31:0] t6_exp;

    always #50 clk = ~clk;

    regfile_sweep #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut1 (
        .Clk(clk), .Reset(rst_n), .Write_reg(we), .W_Addr(wa), .W_Data(wd), .W_Mask(wm),
        .R_Addr_A(ra), .R_Addr_B(rb), .R_Data_A(rda1), .R_Data_B(rdb1),
        .Clear(clr), .Busy(busy1), .Clear_done(done1), .Wr_drop(drop1));

    regfile_sweep #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut0 (
        .Clk(clk), .Reset(rst_n), .Write_reg(we), .W_Addr(wa), .W_Data(wd), .W_Mask(wm),
        .R_Addr_A(ra), .R_Addr_B(rb), .R_Data_A(rda0), .R_Data_B(rdb0),
        .Clear(clr), .Busy(busy0), .Clear_done(done0), .Wr_drop(drop0));

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = m[k] ? d[8*k +: 8] : o[8*k +: 8];
        return r;
    endfunction

    // z=1 models the zero-register instance, z=0 the ordinary one
    function automatic logic [31:0] exp_rd(input int z, input logic [4:0] a);
        if (z == 1 && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && ref_sweep < 0 && a == wa && !(z == 1 && wa == 5'd0))
            return merge(ref_mem[z][a], wd, wm);
`endif
        return ref_mem[z][a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            for (int z = 0; z < 2; z++) for (int i = 0; i < 32; i++) ref_mem[z][i] = 32'h0;
            ref_sweep = -1; ref_done = 1'b0; ref_drop = 1'b0;
        end else if (ref_sweep >= 0) begin
            ref_done = 1'b0;
            ref_drop = we;
            for (int z = 0; z < 2; z++) ref_mem[z][ref_sweep] = 32'h0;
            if (ref_sweep == 31) begin ref_sweep = -1; ref_done = 1'b1; end
            else ref_sweep++;
        end else begin
            ref_done = 1'b0;
            ref_drop = 1'b0;
            if (we) begin
                for (int z = 0; z < 2; z++)
                    if (!(z == 1 && wa == 5'd0)) ref_mem[z][wa] = merge(ref_mem[z][wa], wd, wm);
            end
            if (clr) ref_sweep = 0;
        end
    endtask

    task automatic check_outs();
        chk("busy1", 32'(busy1), 32'(ref_sweep >= 0));
        chk("done1", 32'(done1), 32'(ref_done));
        chk("drop1", 32'(drop1), 32'(ref_drop));
        chk("busy0", 32'(busy0), 32'(ref_sweep >= 0));
        chk("done0", 32'(done0), 32'(ref_done));
        chk("drop0", 32'(drop0), 32'(ref_drop));
        chk("rdA1", rda1, exp_rd(1, ra));
        chk("rdB1", rdb1, exp_rd(1, rb));
        chk("rdA0", rda0, exp_rd(0, ra));
        chk("rdB0", rdb0, exp_rd(0, rb));
    endtask

    task automatic step();
        #1;
        check_outs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic scan();
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a);
            #1;
            chk("scan1", rda1, exp_rd(1, ra));
            chk("scan0", rda0, exp_rd(0, ra));
        end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; clr = 1'b0; wa = 5'd0; wd = 32'h0; wm = 4'h0; ra = 5'd0; rb = 5'd0;
        ref_sweep = -1; ref_done = 1'b0; ref_drop = 1'b0;
        @(posedge clk); model_edge(); #1;
        rst_n = 1'b1;

        // random traffic with occasional clears and resets
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            we    = 1'($urandom_range(0, 1));
            wa    = 5'($urandom); wd = $urandom; wm = 4'($urandom);
            clr   = ($urandom_range(0, 29) == 0);
            ra    = 5'($urandom); rb = 5'($urandom);
            step();
        end
        rst_n = 1'b1; clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wa = 5'($urandom); wd = $urandom; wm = 4'hF; step();
        end

        // T1: reset clears contents and status
        we = 1'b1; wa = 5'd7; rst_n = 1'b0; step();
        rst_n = 1'b1; we = 1'b0;
        chk("T1_busy", 32'(busy1), 32'h0);
        scan();

        // T2: byte-masked write
        we = 1'b1; wa = 5'd5; wd = 32'h11223344; wm = 4'hF; step();
        wd = 32'hDEADBEEF; wm = 4'b0101; step();
        we = 1'b0; ra = 5'd5; #1;
        chk("T2_masked", rda1, 32'h11AD33EF);

        // T3: entry 0 behaviour for both ZERO_REG settings
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; wm = 4'hF; step();
        we = 1'b0; ra = 5'd0; #1;
        chk("T3_zero1", rda1, 32'h0);
        chk("T3_zero0", rda0, 32'hFFFFFFFF);
        chk("T3_nodrop", 32'(drop1), 32'h0);

        // T4: full sweep with a dropped write in sweep cycle 10
        for (int a = 0; a < 32; a++) begin
            we = 1'b1; wa = 5'(a); wd = 32'hA5A5A5A5; wm = 4'hF; step();
        end
        we = 1'b0; clr = 1'b1; step();
        clr = 1'b0; busy_cycles = 0; done_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy1) busy_cycles++;
            if (done1) done_cycles++;
            we = (busy_cycles == 10) && busy1; wa = 5'd3; wd = $urandom; wm = 4'hF;
            ra = 5'($urandom); rb = 5'($urandom);
            step();
        end
        we = 1'b0;
        chk("T4_busy_len", 32'(busy_cycles), 32'd32);
        chk("T4_done_cnt", 32'(done_cycles), 32'd1);
        scan();

        // T5: reset aborts a sweep at cycle 7
        for (int a = 0; a < 32; a++) begin
            we = 1'b1; wa = 5'(a); wd = $urandom; wm = 4'hF; step();
        end
        we = 1'b0; clr = 1'b1; step();
        clr = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        chk("T5_busy", 32'(busy1), 32'h0);
        scan();
        done_cycles = 0;
        for (int i = 0; i < 36; i++) begin
            if (done1) done_cycles++;
            step();
        end
        chk("T5_no_done", 32'(done_cycles), 32'd0);

        // T6: same-cycle read of the entry being written
        we = 1'b1; wa = 5'd9; wd = 32'h0BADF00D; wm = 4'hF; step();
        wd = 32'h12345678; ra = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
        t6_exp = 32'h12345678;
`else
        t6_exp = 32'h0BADF00D;
`endif
        chk("T6_same_cycle", rda1, t6_exp);
        step();
        we = 1'b0; #1;
        chk("T6_next_cycle", rda1, 32'h12345678);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
